// File: rtl/soundrive_ctrl_if.sv
// CPU-side write bus into the Soundrive channel sequencer.
// The master drives the strobe, address and data; the controller samples them.
interface soundrive_ctrl_if;
    logic       wr_stb;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_stb, output wr_addr, output wr_data);
    modport slave  (input  wr_stb, input  wr_addr, input  wr_data);
endinterface

// File: rtl/soundrive_ctrl.sv
// Soundrive DAC channel sequencer.
// Writes go straight to the channels in direct mode, or through a tick-paced FIFO in paced mode.
module soundrive_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter logic [7:0]  IDLE_LEVEL = 8'h00
) (
    input  logic                          clk28,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          paced,
    input  logic                          covox,
    input  logic [DIV_WIDTH-1:0]          tick_div,
    soundrive_ctrl_if.slave               bus,
    input  logic                          ovf_clr,
    output logic [7:0]                    sd_l0,
    output logic [7:0]                    sd_l1,
    output logic [7:0]                    sd_r0,
    output logic [7:0]                    sd_r1,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 paced_q;
    logic [7:0]           ch_q [4];
    logic [7:0]           ch_d [4];
    // Entry layout: {covox, addr[1:0], data[7:0]}
    logic [10:0]          mem_q [FIFO_DEPTH];

    logic run, tick, flush, empty, full, push, pop, push_ok, drop;
    logic       ap_cv;
    logic [1:0] ap_addr;
    logic [7:0] ap_data;
    logic [10:0] head;

    always_comb begin
        run     = en && paced;
        tick    = run && (cnt_q == tick_div);
        // Leaving paced mode is detected against the registered mode bit
        flush   = !en || (paced_q && !paced);
        empty   = (level_q == '0);
        full    = (level_q == LW'(FIFO_DEPTH));
        push    = run && bus.wr_stb;
        pop     = tick && !empty;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        head    = mem_q[rd_ptr_q];
    end

    always_comb begin
        cnt_d    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (run && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + LW'(push_ok) - LW'(pop);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        ap_cv   = 1'b0;
        ap_addr = 2'd0;
        ap_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ch_d[i] = ch_q[i];
        end
        if (!en) begin
            for (int i = 0; i < 4; i++) begin
                ch_d[i] = IDLE_LEVEL;
            end
        end else if (!paced && bus.wr_stb) begin
            ap_cv   = covox;
            ap_addr = bus.wr_addr;
            ap_data = bus.wr_data;
            for (int i = 0; i < 4; i++) begin
                if (ap_cv || (ap_addr == 2'(i))) ch_d[i] = ap_data;
            end
        end else if (pop) begin
            ap_cv   = head[10];
            ap_addr = head[9:8];
            ap_data = head[7:0];
            for (int i = 0; i < 4; i++) begin
                if (ap_cv || (ap_addr == 2'(i))) ch_d[i] = ap_data;
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            paced_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= IDLE_LEVEL;
            end
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            paced_q  <= paced;
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    // Storage needs no reset; validity is tracked by the level counter
    always_ff @(posedge clk28) begin
        if (!rst && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= {covox, bus.wr_addr, bus.wr_data};
        end
    end

    assign sd_l0      = ch_q[0];
    assign sd_l1      = ch_q[1];
    assign sd_r0      = ch_q[2];
    assign sd_r1      = ch_q[3];
    assign fifo_level = level_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_soundrive_ctrl.sv
// Directed bench for soundrive_ctrl: reset, direct, paced, overflow, full push+pop, flush.
module tb_soundrive_ctrl;
    logic        clk28 = 1'b0;
    logic        rst, en, paced, covox, ovf_clr;
    logic [15:0] tick_div;
    logic [7:0]  sd_l0, sd_l1, sd_r0, sd_r1;
    logic [3:0]  fifo_level;
    logic        fifo_full, fifo_empty, overflow;
    int          n_tests = 0;
    int          n_fail  = 0;

    soundrive_ctrl_if bus ();

    soundrive_ctrl dut (
        .clk28      (clk28),
        .rst        (rst),
        .en         (en),
        .paced      (paced),
        .covox      (covox),
        .tick_div   (tick_div),
        .bus        (bus),
        .ovf_clr    (ovf_clr),
        .sd_l0      (sd_l0),
        .sd_l1      (sd_l1),
        .sd_r0      (sd_r0),
        .sd_r1      (sd_r1),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk28 = ~clk28;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk28);
            @(negedge clk28);
        end
    endtask

    task automatic write(input logic cv, input logic [1:0] a, input logic [7:0] d);
        covox           = cv;
        bus.wr_stb      = 1'b1;
        bus.wr_addr     = a;
        bus.wr_data     = d;
        step(1);
        bus.wr_stb      = 1'b0;
        covox           = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; paced = 1'b0; covox = 1'b0; ovf_clr = 1'b0;
        tick_div = 16'd0;
        bus.wr_stb = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00;
        @(negedge clk28);
        step(1);
        rst = 1'b0;

        // Reset state
        check("rst_l0", sd_l0, 8'h00);
        check("rst_r1", sd_r1, 8'h00);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_level", fifo_level, 4'd0);
        check("rst_ovf", overflow, 1'b0);

        // Direct mode
        en = 1'b1;
        write(1'b0, 2'd2, 8'hA5);
        check("dir_r0", sd_r0, 8'hA5);
        check("dir_l0", sd_l0, 8'h00);
        write(1'b1, 2'd0, 8'h3C);
        check("cov_l0", sd_l0, 8'h3C);
        check("cov_l1", sd_l1, 8'h3C);
        check("cov_r0", sd_r0, 8'h3C);
        check("cov_r1", sd_r1, 8'h3C);

        // Paced: divider starts at 0 on the first paced edge, ticks on edges 10, 20, 30
        paced = 1'b1;
        tick_div = 16'd9;
        write(1'b0, 2'd0, 8'h01);
        write(1'b0, 2'd1, 8'h02);
        write(1'b0, 2'd2, 8'h03);
        check("pc_level3", fifo_level, 4'd3);
        step(6);
        check("pc_l0_wait", sd_l0, 8'h3C);
        step(1);
        check("pc_l0_tick", sd_l0, 8'h01);
        check("pc_level2", fifo_level, 4'd2);
        step(9);
        check("pc_l1_wait", sd_l1, 8'h3C);
        step(1);
        check("pc_l1_tick", sd_l1, 8'h02);
        step(10);
        check("pc_r0_tick", sd_r0, 8'h03);
        check("pc_level0", fifo_level, 4'd0);
        check("pc_empty", fifo_empty, 1'b1);

        // Overflow: 9 pushes into a depth-8 queue; the 9th also raises ovf_clr (set wins)
        tick_div = 16'd999;
        for (int i = 0; i < 8; i++) write(1'b0, 2'd0, 8'h10 + 8'(i));
        ovf_clr = 1'b1;
        write(1'b0, 2'd0, 8'h18);
        ovf_clr = 1'b0;
        check("ov_level", fifo_level, 4'd8);
        check("ov_full", fifo_full, 1'b1);
        check("ov_flag", overflow, 1'b1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ov_clr", overflow, 1'b0);

        // Full queue: push lands exactly on the tick edge (count 999)
        step(989);
        check("fp_pre_l0", sd_l0, 8'h01);
        write(1'b0, 2'd1, 8'hEE);
        check("fp_level", fifo_level, 4'd8);
        check("fp_ovf", overflow, 1'b0);
        check("fp_pop", sd_l0, 8'h10);

        // Drain quickly; the dropped 8'h18 must never appear
        tick_div = 16'd3;
        step(32);
        check("dr_empty", fifo_empty, 1'b1);
        check("dr_l0", sd_l0, 8'h17);
        check("dr_l1", sd_l1, 8'hEE);

        // Flush by leaving paced mode; the switch-cycle write goes direct
        tick_div = 16'd999;
        for (int i = 0; i < 4; i++) write(1'b0, 2'd2, 8'h40 + 8'(i));
        check("fl_level4", fifo_level, 4'd4);
        paced = 1'b0;
        write(1'b0, 2'd3, 8'h5A);
        check("fl_level0", fifo_level, 4'd0);
        check("fl_empty", fifo_empty, 1'b1);
        check("fl_r1", sd_r1, 8'h5A);
        check("fl_r0_keep", sd_r0, 8'h03);

        // Flush by disabling
        paced = 1'b1;
        for (int i = 0; i < 4; i++) write(1'b0, 2'd0, 8'h50 + 8'(i));
        check("en_level4", fifo_level, 4'd4);
        en = 1'b0;
        step(1);
        check("en_level0", fifo_level, 4'd0);
        check("en_l0", sd_l0, 8'h00);
        check("en_r1", sd_r1, 8'h00);

        // Reset mid-queue
        en = 1'b1;
        write(1'b0, 2'd1, 8'h77);
        for (int i = 0; i < 3; i++) write(1'b0, 2'd0, 8'h60 + 8'(i));
        check("rq_level4", fifo_level, 4'd4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rq_level0", fifo_level, 4'd0);
        check("rq_empty", fifo_empty, 1'b1);
        check("rq_l1", sd_l1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
